// File: rtl/system_led_sequencer.sv
// LED sequencer: CSR-programmed shadow pattern, rotate/blink engine, and an
// Avalon-MM master that mirrors every shadow change into the LED PIO.
module system_led_sequencer #(
    parameter int unsigned WIDTH          = 10,
    parameter int unsigned PRESCALE_W     = 26,
    parameter int unsigned PRESCALE_RESET = 49999999,
    parameter int unsigned RESET_PATTERN  = 273
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  csr_address,
    input  logic        csr_chipselect,
    input  logic        csr_write_n,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    output logic        busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned CTRL_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_CTRL     = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_PRESCALE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_PATTERN  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = ADDR_W'(3);

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_MODE = 1;
    localparam int unsigned CTRL_DIR  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    state_e                state_q,    state_d;
    logic [CTRL_W-1:0]     ctrl_q,     ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] counter_q,  counter_d;
    logic [WIDTH-1:0]      shadow_q,   shadow_d;
    logic                  pending_q,  pending_d;
    logic                  pio_cs_q,   pio_cs_d;
    logic                  pio_wn_q,   pio_wn_d;
    logic [WIDTH-1:0]      pio_wd_q,   pio_wd_d;
    logic                  busy_q,     busy_d;

    logic                  csr_wr_c;
    logic                  wr_ctrl_c;
    logic                  wr_prescale_c;
    logic                  wr_pattern_c;
    logic                  tick_c;
    logic                  event_c;
    logic [WIDTH-1:0]      next_pattern_c;
    logic                  unused_wdata_c;

    // CSR write decode; STATUS writes are decoded away
    always_comb begin
        csr_wr_c      = csr_chipselect & ~csr_write_n;
        wr_ctrl_c     = csr_wr_c && (csr_address == ADDR_CTRL);
        wr_prescale_c = csr_wr_c && (csr_address == ADDR_PRESCALE);
        wr_pattern_c  = csr_wr_c && (csr_address == ADDR_PATTERN);
    end

    assign unused_wdata_c = ^csr_writedata;

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        if (wr_ctrl_c) begin
            ctrl_d = csr_writedata[CTRL_W-1:0];
        end
        if (wr_prescale_c) begin
            prescale_d = csr_writedata[PRESCALE_W-1:0];
        end
    end

    // Prescaler: free-runs while enabled, restarts on any timing reconfiguration
    always_comb begin
        tick_c    = ctrl_q[CTRL_EN] && (counter_q == prescale_q);
        counter_d = counter_q + PRESCALE_W'(1);
        if (!ctrl_q[CTRL_EN] || wr_ctrl_c || wr_prescale_c || tick_c) begin
            counter_d = '0;
        end
    end

    always_comb begin
        next_pattern_c = {shadow_q[WIDTH-2:0], shadow_q[WIDTH-1]};
        if (ctrl_q[CTRL_MODE]) begin
            next_pattern_c = ~shadow_q;
        end else if (ctrl_q[CTRL_DIR]) begin
            next_pattern_c = {shadow_q[0], shadow_q[WIDTH-1:1]};
        end
    end

    // A CPU pattern load takes priority over a same-cycle engine step
    always_comb begin
        shadow_d = shadow_q;
        if (wr_pattern_c) begin
            shadow_d = csr_writedata[WIDTH-1:0];
        end else if (tick_c) begin
            shadow_d = next_pattern_c;
        end
        event_c = wr_pattern_c | tick_c;
    end

    // PIO master: one-cycle write strobe, events during a strobe coalesce into pending
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        pio_cs_d  = 1'b0;
        pio_wn_d  = 1'b1;
        pio_wd_d  = pio_wd_q;
        unique case (state_q)
            IDLE: begin
                if (event_c || pending_q) begin
                    state_d   = WRITE;
                    pending_d = 1'b0;
                    pio_cs_d  = 1'b1;
                    pio_wn_d  = 1'b0;
                    pio_wd_d  = shadow_d;
                end
            end
            WRITE: begin
                state_d = IDLE;
                if (event_c) begin
                    pending_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == WRITE) | pending_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            prescale_q <= PRESCALE_W'(PRESCALE_RESET);
            counter_q  <= '0;
            shadow_q   <= WIDTH'(RESET_PATTERN);
            pending_q  <= 1'b0;
            pio_cs_q   <= 1'b0;
            pio_wn_q   <= 1'b1;
            pio_wd_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            counter_q  <= counter_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            pio_cs_q   <= pio_cs_d;
            pio_wn_q   <= pio_wn_d;
            pio_wd_q   <= pio_wd_d;
            busy_q     <= busy_d;
        end
    end

    // Zero-wait-state CSR readback
    always_comb begin
        csr_readdata = '0;
        unique case (csr_address)
            ADDR_CTRL:     csr_readdata = DATA_W'(ctrl_q);
            ADDR_PRESCALE: csr_readdata = DATA_W'(prescale_q);
            ADDR_PATTERN:  csr_readdata = DATA_W'(shadow_q);
            ADDR_STATUS:   csr_readdata = DATA_W'({pending_q, busy_q});
            default:       csr_readdata = '0;
        endcase
    end

    assign pio_address    = '0;
    assign pio_chipselect = pio_cs_q;
    assign pio_write_n    = pio_wn_q;
    assign pio_writedata  = DATA_W'(pio_wd_q);
    assign busy           = busy_q;

endmodule

// File: tb/tb_system_led_sequencer.sv
// Scoreboard bench for system_led_sequencer: a time-based reference model predicts
// every PIO write; a monitor pops and compares each strobe the DUT presents.
module tb_system_led_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  csr_address;
    logic        csr_chipselect;
    logic        csr_write_n;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic        busy;

    system_led_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .csr_address    (csr_address),
        .csr_chipselect (csr_chipselect),
        .csr_write_n    (csr_write_n),
        .csr_writedata  (csr_writedata),
        .csr_readdata   (csr_readdata),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [9:0] exp_q[$];

    // Reference model state
    int unsigned m_ctrl, m_pre, m_shadow, m_cnt;
    bit          m_pending;
    int          m_cyc, m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned next_pat(input int unsigned s, input int unsigned ctrl);
        if ((ctrl & 2) != 0) return s ^ 32'h3FF;
        if ((ctrl & 4) != 0) return (s >> 1) | ((s & 1) << 9);
        return ((s << 1) | (s >> 9)) & 32'h3FF;
    endfunction

    task automatic model_reset();
        m_ctrl    = 0;
        m_pre     = 49999999;
        m_shadow  = 273;
        m_cnt     = 0;
        m_pending = 0;
        m_cyc     = 0;
        m_last    = -10;
        exp_q.delete();
    endtask

    // A write leaves at an event edge unless one left the previous edge; then it waits one edge
    task automatic model_edge(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        bit          wr, en, tick, pat;
        int unsigned ns;
        wr   = cs && !wn;
        en   = (m_ctrl & 1) != 0;
        tick = en && (m_cnt == m_pre);
        pat  = wr && (a == 2'd2);
        ns   = pat ? (wd & 32'h3FF) : (tick ? next_pat(m_shadow, m_ctrl) : m_shadow);
        m_cyc++;
        if ((pat || tick || m_pending) && (m_last != m_cyc - 1)) begin
            exp_q.push_back(ns[9:0]);
            m_last    = m_cyc;
            m_pending = 0;
        end else if (pat || tick) begin
            m_pending = 1;
        end
        if (!en || tick || (wr && a <= 2'd1)) m_cnt = 0;
        else m_cnt = m_cnt + 1;
        if (wr && a == 2'd0) m_ctrl = wd & 7;
        if (wr && a == 2'd1) m_pre = wd & 32'h03FF_FFFF;
        m_shadow = ns;
    endtask

    function automatic logic model_busy();
        return (m_last == m_cyc) || m_pending;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_ctrl;
            2'd1:    return m_pre;
            2'd2:    return m_shadow;
            default: return {30'd0, m_pending, model_busy()};
        endcase
    endfunction

    // One cycle: drive at negedge, check reads, advance model at posedge, check busy at negedge
    task automatic step(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        csr_address    = a;
        csr_chipselect = cs;
        csr_write_n    = wn;
        csr_writedata  = wd;
        #1;
        if (cs && wn) check("csr_read", csr_readdata, model_read(a));
        @(posedge clk);
        model_edge(a, cs, wn, wd);
        @(negedge clk);
        check("busy", {31'd0, busy}, {31'd0, model_busy()});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'd0, 1'b0, 1'b1, 32'd0);
    endtask

    task automatic wr_csr(input logic [1:0] a, input logic [31:0] d);
        step(a, 1'b1, 1'b0, d);
    endtask

    task automatic rd_csr(input logic [1:0] a);
        step(a, 1'b1, 1'b1, 32'd0);
    endtask

    // Monitor: every strobe must match the oldest predicted write and last one cycle
    bit prev_strobe = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_strobe = 0;
        end else if (pio_chipselect && !pio_write_n) begin
            check("strobe_width", {31'd0, prev_strobe}, 32'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got 0x%0h expected no write at %0t", pio_writedata, $time);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("pio_writedata", pio_writedata, {22'd0, e});
                check("pio_address", {30'd0, pio_address}, 32'd0);
            end
            prev_strobe = 1;
        end else begin
            prev_strobe = 0;
        end
    end

    initial begin
        reset          = 1'b1;
        csr_address    = 2'd0;
        csr_chipselect = 1'b0;
        csr_write_n    = 1'b1;
        csr_writedata  = 32'd0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Quiet after reset, reset values visible
        idle(20);
        for (int a = 0; a < 4; a++) rd_csr(2'(a));

        // Manual load with engine off
        wr_csr(2'd2, 32'h0000_02AA);
        idle(3);
        rd_csr(2'd3);

        // Rotate left, then right
        wr_csr(2'd2, 32'h0000_0111);
        wr_csr(2'd1, 32'd3);
        wr_csr(2'd0, 32'h1);
        idle(16);
        wr_csr(2'd0, 32'h5);
        idle(10);
        rd_csr(2'd2);

        // Blink every cycle with coalescing
        wr_csr(2'd0, 32'h0);
        wr_csr(2'd2, 32'h0000_00F0);
        wr_csr(2'd1, 32'd0);
        wr_csr(2'd0, 32'h3);
        for (int i = 0; i < 15; i++) begin
            if (i % 3 == 0) rd_csr(2'd3);
            else idle(1);
        end
        wr_csr(2'd0, 32'h0);
        idle(4);
        rd_csr(2'd2);

        // Pattern load colliding with a tick
        wr_csr(2'd1, 32'd5);
        wr_csr(2'd0, 32'h1);
        for (int i = 0; i < 20 && m_cnt != m_pre; i++) idle(1);
        wr_csr(2'd2, 32'h0000_0155);
        idle(12);
        rd_csr(2'd2);
        wr_csr(2'd0, 32'h0);
        idle(4);

        // Asynchronous reset during a write strobe
        csr_address    = 2'd2;
        csr_chipselect = 1'b1;
        csr_write_n    = 1'b0;
        csr_writedata  = 32'h0000_01AB;
        @(posedge clk);
        model_edge(2'd2, 1'b1, 1'b0, 32'h0000_01AB);
        #1;
        check("strobe_before_reset", {31'd0, pio_chipselect}, 32'd1);
        reset = 1'b1;
        #1;
        check("async_strobe_drop", {31'd0, pio_chipselect}, 32'd0);
        model_reset();
        @(negedge clk);
        csr_chipselect = 1'b0;
        csr_write_n    = 1'b1;
        reset          = 1'b0;
        for (int a = 0; a < 4; a++) rd_csr(2'(a));
        idle(5);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            case (r)
                0:       wr_csr(2'd0, $urandom);
                1:       wr_csr(2'd1, 32'($urandom_range(0, 6)));
                2, 3:    wr_csr(2'd2, $urandom);
                4:       wr_csr(2'd3, $urandom);
                5:       rd_csr(2'($urandom_range(0, 3)));
                6:       step(2'($urandom_range(0, 3)), 1'b0, 1'b0, $urandom);
                default: idle(1);
            endcase
        end

        // Drain: stop the engine and let any pending write leave
        wr_csr(2'd0, 32'h0);
        idle(6);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
